// File: rtl/surf_status_pkg.sv
// Shared types, frame layout and frame-building helpers for the SURF->TURF status link.
package surf_status_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_e;

    localparam logic [1:0] STAT_RESERVED      = 2'b00;
    localparam logic [1:0] STAT_DIGITIZE_DONE = 2'b01;
    localparam logic [1:0] STAT_READOUT_DONE  = 2'b10;
    localparam logic [1:0] STAT_ERROR         = 2'b11;

    localparam int FRAME_BITS = 39;
    localparam int REQ_BITS   = 36;

    // Bit positions inside the 39-bit frame; bit 38 leaves the wire first.
    localparam int OFF_START = 38;
    localparam int OFF_TYPE  = 36;
    localparam int OFF_BUF   = 34;
    localparam int OFF_EID   = 2;
    localparam int OFF_PAR   = 1;
    localparam int OFF_STOP  = 0;

    typedef struct packed {
        logic [1:0]  req_type;
        logic [1:0]  buffer;
        logic [31:0] event_id;
    } stat_req_t;

    function automatic logic even_parity(input stat_req_t req);
        return ^req;
    endfunction

    function automatic logic [FRAME_BITS-1:0] build_frame(input stat_req_t req);
        logic [FRAME_BITS-1:0] frame;
        frame                           = '0;
        frame[OFF_START]                = 1'b1;
        frame[OFF_TYPE +: 2]            = req.req_type;
        frame[OFF_BUF +: 2]             = req.buffer;
        frame[OFF_EID +: 32]            = req.event_id;
        frame[OFF_PAR]                  = even_parity(req);
        frame[OFF_STOP]                 = 1'b0;
        return frame;
    endfunction

endpackage

// File: rtl/surf_status_fifo.sv
// Synchronous request queue; head word is presented combinationally, count is registered.
module surf_status_fifo
    import surf_status_pkg::*;
#(
    parameter int WIDTH = REQ_BITS,
    parameter int DEPTH = 4
) (
    input  logic                       clk33_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Full and empty are judged on the count before this cycle's pop.
    assign push_ok_s = push && (count_r != FULL_COUNT);
    assign pop_ok_s  = pop && (count_r != {CW{1'b0}});
    assign pop_data  = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array write port.
    always_ff @(posedge clk33_i) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/surf_status_transmitter.sv
// SURF->TURF status transmitter: queues status requests and sends each as a
// 39-bit framed serial word (START, TYPE, BUF, EID, PAR, STOP) followed by an idle gap.
module surf_status_transmitter
    import surf_status_pkg::*;
#(
    parameter int BIT_CYCLES = 1,
    parameter int GAP_CYCLES = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk33_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [1:0]  req_type_i,
    input  logic [1:0]  req_buffer_i,
    input  logic [31:0] req_event_id_i,
    output logic        req_ready_o,
    output logic        drop_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        stat_o,
    output logic        stat_debug_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0] SUB_LAST  = 4'(BIT_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam logic [5:0] BIT_FIRST = 6'(FRAME_BITS - 1);

    tx_state_e             state_r;
    tx_state_e             state_s;
    logic [FRAME_BITS-1:0] shift_r;
    logic [5:0]            bit_cnt_r;
    logic [3:0]            sub_cnt_r;
    logic [7:0]            gap_cnt_r;
    logic                  stat_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  drop_r;
    logic                  stat_s;
    logic                  busy_s;
    logic                  done_s;

    logic [CNT_W-1:0]      fifo_count_s;
    stat_req_t             req_s;
    stat_req_t             head_s;
    logic                  req_valid_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  drop_s;
    logic                  bit_last_s;
    logic                  frame_last_s;
    logic                  gap_last_s;

    assign req_s        = '{req_type: req_type_i, buffer: req_buffer_i, event_id: req_event_id_i};
    assign fifo_full_s  = (fifo_count_s == FULL_COUNT);
    assign fifo_empty_s = (fifo_count_s == {CNT_W{1'b0}});
    // Reserved type 00 is neither queued nor reported as a drop.
    assign req_valid_s  = req_i && (req_type_i != STAT_RESERVED);
    assign push_s       = req_valid_s && !fifo_full_s;
    assign drop_s       = req_valid_s && fifo_full_s;
    assign pop_s        = (state_r == ST_IDLE) && !fifo_empty_s;
    assign bit_last_s   = (sub_cnt_r == SUB_LAST);
    assign frame_last_s = (state_r == ST_SHIFT) && bit_last_s && (bit_cnt_r == 6'd0);
    assign gap_last_s   = (state_r == ST_GAP) && (gap_cnt_r == GAP_LAST);

    assign req_ready_o  = !fifo_full_s;
    assign drop_o       = drop_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign stat_o       = stat_r;
    assign stat_debug_o = stat_r;

    surf_status_fifo #(
        .WIDTH (REQ_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk33_i   (clk33_i),
        .rst_i     (rst_i),
        .push      (push_s),
        .push_data (req_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .count     (fifo_count_s)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_s = state_r;
        stat_s  = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                stat_s = shift_r[FRAME_BITS-1];
                busy_s = 1'b1;
                if (frame_last_s) begin
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_GAP: begin
                busy_s = 1'b1;
                if (gap_last_s) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            stat_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            stat_r  <= stat_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            drop_r  <= drop_s;
        end
    end

    // Shift register and bit/gap timing counters.
    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            shift_r   <= {FRAME_BITS{1'b0}};
            bit_cnt_r <= 6'd0;
            sub_cnt_r <= 4'd0;
            gap_cnt_r <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_r   <= build_frame(head_s);
                        bit_cnt_r <= BIT_FIRST;
                        sub_cnt_r <= 4'd0;
                        gap_cnt_r <= 8'd0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_last_s) begin
                        sub_cnt_r <= 4'd0;
                        shift_r   <= {shift_r[FRAME_BITS-2:0], 1'b0};
                        if (bit_cnt_r != 6'd0) begin
                            bit_cnt_r <= bit_cnt_r - 6'd1;
                        end
                    end else begin
                        sub_cnt_r <= sub_cnt_r + 4'd1;
                    end
                end
                ST_GAP: begin
                    gap_cnt_r <= gap_cnt_r + 8'd1;
                end
                default: begin
                    shift_r   <= {FRAME_BITS{1'b0}};
                    bit_cnt_r <= 6'd0;
                    sub_cnt_r <= 4'd0;
                    gap_cnt_r <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_surf_status_transmitter.sv
// Scoreboard bench: two transmitters (BIT_CYCLES 1 and 3) with a serial frame decoder per instance.
module tb_surf_status_transmitter;
    localparam int GAP   = 4;
    localparam int BC0   = 1;
    localparam int BC1   = 3;

    logic clk = 1'b0;
    always #15 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst0, req0, ready0, drop0, busy0, done0, stat0, dbg0;
    logic [1:0]  typ0, buf0;
    logic [31:0] eid0;
    logic        rst1, req1, ready1, drop1, busy1, done1, stat1, dbg1;
    logic [1:0]  typ1, buf1;
    logic [31:0] eid1;

    surf_status_transmitter #(.BIT_CYCLES(BC0), .GAP_CYCLES(GAP), .FIFO_DEPTH(4)) dut0 (
        .clk33_i(clk), .rst_i(rst0), .req_i(req0), .req_type_i(typ0), .req_buffer_i(buf0),
        .req_event_id_i(eid0), .req_ready_o(ready0), .drop_o(drop0), .busy_o(busy0),
        .done_o(done0), .stat_o(stat0), .stat_debug_o(dbg0));

    surf_status_transmitter #(.BIT_CYCLES(BC1), .GAP_CYCLES(GAP), .FIFO_DEPTH(4)) dut1 (
        .clk33_i(clk), .rst_i(rst1), .req_i(req1), .req_type_i(typ1), .req_buffer_i(buf1),
        .req_event_id_i(eid1), .req_ready_o(ready1), .drop_o(drop1), .busy_o(busy1),
        .done_o(done1), .stat_o(stat1), .stat_debug_o(dbg1));

    logic [35:0] exp0[$];
    logic [35:0] exp1[$];
    int          starts0[$];
    logic [38:0] last_fr0, last_fr1;
    int          drops0 = 0;
    int          drops1 = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          acc_cyc = 0;

    always @(negedge clk) begin
        if (drop0) drops0 <= drops0 + 1;
        if (drop1) drops1 <= drops1 + 1;
    end

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? exp0.size() : exp1.size();
    endfunction

    // Frame decoder + scoreboard for instance k.
    task automatic monitor(input int k);
        int bc, phase, bitn, sub, gapn, t0;
        bit ok, post_gap;
        logic s, dbg, bz, dn, r;
        logic [38:0] fr, expf;
        logic [35:0] d;
        bc = (k == 0) ? BC0 : BC1;
        phase = 0; bitn = 0; sub = 0; gapn = 0; t0 = 0; ok = 1'b1; post_gap = 1'b0; fr = '0;
        forever begin
            @(negedge clk);
            if (k == 0) begin s = stat0; dbg = dbg0; bz = busy0; dn = done0; r = rst0; end
            else        begin s = stat1; dbg = dbg1; bz = busy1; dn = done1; r = rst1; end
            if (r) begin
                phase = 0; post_gap = 1'b0;
            end else begin
                case (phase)
                    0: begin
                        if (dn) check(1'b0, "done_outside_gap", 64'(dn), 64'd0);
                        if (post_gap) begin
                            check(!bz, "busy_fall", 64'(bz), 64'd0);
                            post_gap = 1'b0;
                        end
                        if (s) begin
                            phase = 1; fr = '0; fr[38] = 1'b1; bitn = 38; sub = 1; t0 = cyc;
                            ok = bz && (dbg == s);
                            if (k == 0) starts0.push_back(cyc);
                        end
                    end
                    1: begin
                        if (sub < bc) begin
                            ok = ok && (s == fr[bitn]);
                            sub++;
                        end else begin
                            bitn--;
                            fr[bitn] = s;
                            sub = 1;
                        end
                        ok = ok && bz && !dn && (dbg == s);
                        if (bitn == 0 && sub == bc) begin
                            check(ok, "bit_hold_busy", 64'(ok), 64'd1);
                            check((cyc - t0 + 1) == 39 * bc, "frame_len", 64'(cyc - t0 + 1), 64'(39 * bc));
                            if (qsize(k) == 0) begin
                                check(1'b0, "unexpected_frame", 64'(fr), 64'd0);
                            end else begin
                                d = (k == 0) ? exp0.pop_front() : exp1.pop_front();
                                expf = {1'b1, d, ^d, 1'b0};
                                check(fr == expf, "frame", 64'(fr), 64'(expf));
                            end
                            if (k == 0) last_fr0 = fr; else last_fr1 = fr;
                            phase = 2; gapn = 0;
                        end
                    end
                    2: begin
                        gapn++;
                        check(!s && bz && (dn == (gapn == GAP)), "gap",
                              64'({s, bz, dn}), 64'({1'b0, 1'b1, (gapn == GAP)}));
                        if (gapn == GAP) begin phase = 0; post_gap = 1'b1; end
                    end
                    default: phase = 0;
                endcase
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // Present a request for one cycle; returns just after the accepting edge.
    task automatic put(input int k, input logic [1:0] t, input logic [1:0] b, input logic [31:0] e, input bit acc);
        if (k == 0) begin req0 = 1'b1; typ0 = t; buf0 = b; eid0 = e; end
        else        begin req1 = 1'b1; typ1 = t; buf1 = b; eid1 = e; end
        if (acc) begin
            if (k == 0) exp0.push_back({t, b, e}); else exp1.push_back({t, b, e});
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
    endtask

    task automatic idle_in(input int k);
        if (k == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain(input int k, input int limit, input string name);
        int n = 0;
        while (qsize(k) != 0 && n < limit) begin step(1); n++; end
        check(qsize(k) == 0, name, 64'(qsize(k)), 64'd0);
        step(GAP + 4);
    endtask

    initial begin
        int hi_cnt, dn_cnt, d0;
        logic [1:0] t, b;
        logic [31:0] e;
        rst0 = 1'b1; rst1 = 1'b1; req0 = 1'b0; req1 = 1'b0;
        typ0 = 2'b00; buf0 = 2'b00; eid0 = 32'd0; typ1 = 2'b00; buf1 = 2'b00; eid1 = 32'd0;
        step(2);
        rst0 = 1'b0; rst1 = 1'b0;
        check({stat0, dbg0, busy0, done0, drop0, ready0} == 6'b000001, "reset0",
              64'({stat0, dbg0, busy0, done0, drop0, ready0}), 64'h1);
        check({stat1, dbg1, busy1, done1, drop1, ready1} == 6'b000001, "reset1",
              64'({stat1, dbg1, busy1, done1, drop1, ready1}), 64'h1);
        step(2);

        // 1: single frame and latency
        starts0.delete();
        put(0, 2'b01, 2'b00, 32'h12345678, 1'b1);
        idle_in(0);
        wait_drain(0, 200, "drain_t1");
        check(starts0.size() == 1 && starts0[0] - acc_cyc == 2, "latency",
              64'(starts0.size() > 0 ? starts0[0] - acc_cyc : -1), 64'd2);
        check(last_fr0 == {1'b1, 2'b01, 2'b00, 32'h12345678, 1'b0, 1'b0}, "frame_t1",
              64'(last_fr0), 64'({1'b1, 2'b01, 2'b00, 32'h12345678, 1'b0, 1'b0}));

        // 2: overflow while busy
        starts0.delete();
        put(0, 2'b10, 2'b01, 32'hA5A5_0001, 1'b1);
        idle_in(0);
        step(3);
        check(busy0 == 1'b1, "busy_t2", 64'(busy0), 64'd1);
        put(0, 2'b01, 2'b00, 32'h0000_0011, 1'b1);
        put(0, 2'b10, 2'b01, 32'h0000_0022, 1'b1);
        put(0, 2'b11, 2'b10, 32'h0000_0033, 1'b1);
        check(ready0 == 1'b1, "ready_before_full", 64'(ready0), 64'd1);
        put(0, 2'b01, 2'b11, 32'h8000_0044, 1'b1);
        check(ready0 == 1'b0, "ready_full", 64'(ready0), 64'd0);
        d0 = drops0;
        put(0, 2'b11, 2'b11, 32'hDEAD_BEEF, 1'b0);
        idle_in(0);
        check(drop0 == 1'b1, "drop_pulse", 64'(drop0), 64'd1);
        step(1);
        check(drop0 == 1'b0, "drop_single", 64'(drop0), 64'd0);
        wait_drain(0, 400, "drain_t2");
        check(drops0 - d0 == 1, "drop_count_t2", 64'(drops0 - d0), 64'd1);
        check(starts0.size() == 5, "frames_t2", 64'(starts0.size()), 64'd5);
        for (int i = 1; i < starts0.size(); i++)
            check(starts0[i] - starts0[i-1] == 44, "spacing", 64'(starts0[i] - starts0[i-1]), 64'd44);

        // 3: reserved type
        d0 = drops0; hi_cnt = 0;
        put(0, 2'b00, 2'b10, 32'hCAFE_F00D, 1'b0);
        idle_in(0);
        for (int i = 0; i < 12; i++) begin
            if (stat0 || busy0 || !ready0) hi_cnt++;
            step(1);
        end
        check(hi_cnt == 0, "reserved_idle", 64'(hi_cnt), 64'd0);
        check(drops0 == d0, "reserved_nodrop", 64'(drops0 - d0), 64'd0);

        // 4: BIT_CYCLES=3 frames
        put(1, 2'b11, 2'b11, 32'hFFFF_FFFF, 1'b1);
        idle_in(1);
        wait_drain(1, 400, "drain_t4");
        check(last_fr1 == {1'b1, 2'b11, 2'b11, 32'hFFFF_FFFF, 1'b0, 1'b0}, "frame_t4",
              64'(last_fr1), 64'({1'b1, 2'b11, 2'b11, 32'hFFFF_FFFF, 1'b0, 1'b0}));
        put(1, 2'b10, 2'b01, 32'h0000_0001, 1'b1);
        idle_in(1);
        wait_drain(1, 400, "drain_t4b");
        check(last_fr1 == {1'b1, 2'b10, 2'b01, 32'h0000_0001, 1'b1, 1'b0}, "frame_t4b",
              64'(last_fr1), 64'({1'b1, 2'b10, 2'b01, 32'h0000_0001, 1'b1, 1'b0}));

        // 5: reset mid-frame with two queued
        put(0, 2'b01, 2'b01, 32'h1111_1111, 1'b1);
        put(0, 2'b10, 2'b10, 32'h2222_2222, 1'b1);
        put(0, 2'b11, 2'b11, 32'h3333_3333, 1'b1);
        idle_in(0);
        step(19);
        check(busy0 == 1'b1, "busy_before_rst", 64'(busy0), 64'd1);
        rst0 = 1'b1;
        exp0.delete();
        step(1);
        rst0 = 1'b0;
        check({stat0, ready0, done0, busy0} == 4'b0100, "post_reset",
              64'({stat0, ready0, done0, busy0}), 64'h4);
        hi_cnt = 0; dn_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            if (stat0) hi_cnt++;
            if (done0) dn_cnt++;
            step(1);
        end
        check(hi_cnt == 0 && dn_cnt == 0, "no_resume", 64'({hi_cnt[15:0], dn_cnt[15:0]}), 64'd0);

        // 6: loopback of random requests at frame rate
        d0 = drops0;
        for (int i = 0; i < 200; i++) begin
            t = 2'($urandom_range(1, 3));
            b = 2'($urandom_range(0, 3));
            e = $urandom;
            put(0, t, b, e, 1'b1);
            idle_in(0);
            step(43);
        end
        wait_drain(0, 400, "drain_t6");
        check(drops0 == d0, "no_drops_t6", 64'(drops0 - d0), 64'd0);
        check(drops1 == 0, "no_drops_dut1", 64'(drops1), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
